picobus_arbiter: RTL and testbench

- Round-robin arbiter that shares a single 32-bit PicoBus master port between NUM_REQ on-chip requesters (e.g. DMA engine, host bridge, debug port).
- Each requester issues single read or write transactions through a valid/ready handshake and receives a one-cycle response pulse.
- The arbiter drives PicoAddr/PicoDataIn/PicoRd/PicoWr to all PicoBus slaves.
- It samples the OR-combined slave read bus, PicoDataOut, READ_LATENCY cycles after the read strobe.

---
 rtl/picobus_arbiter.sv | 160 ++++++++++++++++
 tb/tb_picobus_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/picobus_arbiter.sv
// Round-robin arbiter sharing one PicoBus master port between NUM_REQ requesters.
// Define PICOBUS_ARB_PRIO_EN to give requester 0 fixed highest priority.
//
// state | meaning
// IDLE  | waiting for a request; grant selected and accepted combinationally
// ISSUE | one-cycle PicoRd or PicoWr strobe
// WAIT  | counting down READ_LATENCY before sampling PicoDataOut
// DONE  | one-cycle rsp_valid pulse to the granted requester
module picobus_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int READ_LATENCY = 1
) (
  input  logic                   PicoClk,
  input  logic                   PicoRst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_wr,
  input  logic [NUM_REQ*32-1:0]  req_addr,
  input  logic [NUM_REQ*32-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [31:0]            rsp_rdata,
  output logic [31:0]            PicoAddr,
  output logic [31:0]            PicoDataIn,
  output logic                   PicoRd,
  output logic                   PicoWr,
  input  logic [31:0]            PicoDataOut,
  output logic [1:0]             grant_id,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arbState;

  localparam logic [1:0] LatLoad = 2'(READ_LATENCY - 1);
  localparam logic [1:0] LastReq = 2'(NUM_REQ - 1);

  arbState state, stateNext;
  logic [1:0]   rrPtr;
  logic [1:0]   waitCnt;
  logic         wrFlag;
  logic         anyValid;
  logic [1:0]   grantSel;
  logic         found;
  logic [2:0]   cand;
  logic [3:0]   validPad, wrPad;
  logic [127:0] addrPad, wdataPad;
  logic [NUM_REQ-1:0] rspOneHot;

  // Pad to the 4-requester maximum so unused packing bits read as 0
  always_comb begin
    validPad = '0;
    wrPad    = '0;
    addrPad  = '0;
    wdataPad = '0;
    validPad[NUM_REQ-1:0]    = req_valid;
    wrPad[NUM_REQ-1:0]       = req_wr;
    addrPad[NUM_REQ*32-1:0]  = req_addr;
    wdataPad[NUM_REQ*32-1:0] = req_wdata;
  end

  assign anyValid = |req_valid;

  always_comb begin
    grantSel = '0;
    found    = 1'b0;
    cand     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, rrPtr} + 3'(i);
      if (cand >= 3'(NUM_REQ)) cand = cand - 3'(NUM_REQ);
      if (!found && validPad[cand[1:0]]) begin
        found    = 1'b1;
        grantSel = cand[1:0];
      end
    end
`ifdef PICOBUS_ARB_PRIO_EN
    if (req_valid[0]) grantSel = 2'd0;
`endif
  end

  always_comb begin
    req_ready = '0;
    if (PicoRst_n && state == IDLE && anyValid) begin
      for (int i = 0; i < NUM_REQ; i++) req_ready[i] = (grantSel == 2'(i));
    end
  end

  always_comb begin
    rspOneHot = '0;
    for (int i = 0; i < NUM_REQ; i++) rspOneHot[i] = (grant_id == 2'(i));
  end

  always_ff @(posedge PicoClk or negedge PicoRst_n) begin
    if (!PicoRst_n) state <= IDLE;
    else            state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (anyValid) stateNext = ISSUE;
      ISSUE:   stateNext = wrFlag ? DONE : WAIT;
      WAIT:    if (waitCnt == 2'd0) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge PicoClk or negedge PicoRst_n) begin
    if (!PicoRst_n) begin
      rrPtr      <= LastReq;
      waitCnt    <= '0;
      wrFlag     <= 1'b0;
      PicoAddr   <= '0;
      PicoDataIn <= '0;
      PicoRd     <= 1'b0;
      PicoWr     <= 1'b0;
      grant_id   <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      busy       <= 1'b0;
    end else begin
      PicoRd    <= 1'b0;
      PicoWr    <= 1'b0;
      rsp_valid <= '0;
      case (state)
        IDLE: if (anyValid) begin
          PicoAddr   <= addrPad[{grantSel, 5'd0} +: 32];
          PicoDataIn <= wdataPad[{grantSel, 5'd0} +: 32];
          grant_id   <= grantSel;
          wrFlag     <= wrPad[grantSel];
          PicoWr     <= wrPad[grantSel];
          PicoRd     <= ~wrPad[grantSel];
`ifdef PICOBUS_ARB_PRIO_EN
          if (grantSel != 2'd0) rrPtr <= grantSel;
`else
          rrPtr <= grantSel;
`endif
        end
        ISSUE: begin
          if (wrFlag) begin
            rsp_rdata <= '0;
            rsp_valid <= rspOneHot;
          end else begin
            waitCnt <= LatLoad;
          end
        end
        WAIT: begin
          if (waitCnt == 2'd0) begin
            rsp_rdata <= PicoDataOut;
            rsp_valid <= rspOneHot;
          end else begin
            waitCnt <= waitCnt - 2'd1;
          end
        end
        default: ;
      endcase
      busy <= (stateNext != IDLE);
    end
  end

endmodule

// File: tb/tb_picobus_arbiter.sv
// Randomized bench for picobus_arbiter with a transaction-timeline reference model.
// Honours PICOBUS_ARB_PRIO_EN when defined for the build.
module tb_picobus_arbiter;
  localparam int NR = 3;
  localparam int RL = 3;

  logic            PicoClk = 1'b0;
  logic            PicoRst_n = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_wr = '0;
  logic [NR*32-1:0] req_addr = '0;
  logic [NR*32-1:0] req_wdata = '0;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   rsp_valid;
  logic [31:0]     rsp_rdata;
  logic [31:0]     PicoAddr;
  logic [31:0]     PicoDataIn;
  logic            PicoRd;
  logic            PicoWr;
  logic [31:0]     PicoDataOut = '0;
  logic [1:0]      grant_id;
  logic            busy;

  picobus_arbiter #(.NUM_REQ(NR), .READ_LATENCY(RL)) dut (
    .PicoClk(PicoClk), .PicoRst_n(PicoRst_n),
    .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .PicoAddr(PicoAddr), .PicoDataIn(PicoDataIn), .PicoRd(PicoRd), .PicoWr(PicoWr),
    .PicoDataOut(PicoDataOut), .grant_id(grant_id), .busy(busy)
  );

  always #5 PicoClk = ~PicoClk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: t counts cycles since acceptance (0 = idle)
  int t = 0;
  int ptr = NR - 1;
  int curId = 0;
  int dur = 0;
  int mG;
  bit curWr = 1'b0;
  logic [31:0] eAddr = '0, eData = '0, eRdata = '0, eReady, eRsp;
  logic [1:0]  eGid = '0;

  function automatic int pick(input logic [NR-1:0] v, input int p);
`ifdef PICOBUS_ARB_PRIO_EN
    if (v[0]) return 0;
`endif
    for (int k = 1; k <= NR; k++) begin
      if (v[(p + k) % NR]) return (p + k) % NR;
    end
    return -1;
  endfunction

  always @(negedge PicoClk) begin
    if (!PicoRst_n) begin
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_strobes", 32'({PicoRd, PicoWr}), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_grant_id", 32'(grant_id), 32'd0);
      chk("rst_addr", PicoAddr, 32'd0);
      chk("rst_wdata", PicoDataIn, 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      t = 0; ptr = NR - 1; curWr = 1'b0; curId = 0;
      eAddr = '0; eData = '0; eRdata = '0; eGid = '0;
    end else begin
      mG = (t == 0) ? pick(req_valid, ptr) : -1;
      eReady = (mG >= 0) ? (32'd1 << mG) : 32'd0;
      dur = curWr ? 3 : 3 + RL;
      eRsp = (t >= 1 && t == dur - 1) ? (32'd1 << curId) : 32'd0;
      chk("req_ready", 32'(req_ready), eReady);
      chk("PicoWr", 32'(PicoWr), 32'(t == 1 && curWr));
      chk("PicoRd", 32'(PicoRd), 32'(t == 1 && !curWr));
      chk("busy", 32'(busy), 32'(t >= 1));
      chk("rsp_valid", 32'(rsp_valid), eRsp);
      chk("rsp_rdata", rsp_rdata, eRdata);
      chk("PicoAddr", PicoAddr, eAddr);
      chk("PicoDataIn", PicoDataIn, eData);
      chk("grant_id", 32'(grant_id), 32'(eGid));
      if (t == 0) begin
        if (mG >= 0) begin
          t = 1;
          curId = mG;
          curWr = req_wr[mG];
          eAddr = req_addr[mG*32 +: 32];
          eData = req_wdata[mG*32 +: 32];
          eGid = 2'(mG);
`ifdef PICOBUS_ARB_PRIO_EN
          if (mG != 0) ptr = mG;
`else
          ptr = mG;
`endif
        end
      end else begin
        if (t == 1 && curWr) eRdata = '0;
        if (t == 1 + RL && !curWr) eRdata = PicoDataOut;
        t++;
        if (t == dur) t = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge PicoClk);
    #1;
  endtask

  task automatic smp();
    @(negedge PicoClk);
  endtask

  int order[$];
  int accCyc[$];
  int cnt[2];
  logic [1:0] lastAcc;
  logic [NR-1:0] acc;
  int cc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) smp();
    @(posedge PicoClk); #2 PicoRst_n = 1'b1;

    // Single write from requester 0
    cyc(); req_valid = 3'b001; req_wr = 3'b001;
    req_addr[31:0] = 32'h4; req_wdata[31:0] = 32'h12345678;
    smp(); chk("w_ready", 32'(req_ready), 32'h1);
    cyc(); req_valid = '0;
    smp(); chk("w_PicoWr", 32'(PicoWr), 32'h1); chk("w_PicoRd", 32'(PicoRd), 32'h0);
    chk("w_addr", PicoAddr, 32'h4); chk("w_data", PicoDataIn, 32'h12345678);
    cyc(); smp(); chk("w_rsp", 32'(rsp_valid), 32'h1); chk("w_rdata", rsp_rdata, 32'h0);
    cyc(); smp(); chk("w_busy_after", 32'(busy), 32'h0);

    // Single read from requester 1
    cyc(); req_valid = 3'b010; req_wr = '0; req_addr[63:32] = 32'hC; PicoDataOut = '0;
    smp(); chk("r_ready", 32'(req_ready), 32'h2);
    cyc(); req_valid = '0;
    smp(); chk("r_PicoRd", 32'(PicoRd), 32'h1); chk("r_addr", PicoAddr, 32'hC);
    chk("r_gid", 32'(grant_id), 32'h1);
    for (int c = 2; c <= 2 + RL; c++) begin
      cyc(); PicoDataOut = (c == 1 + RL) ? 32'hDEADBEEF : 32'h55AA55AA;
      smp();
      if (c < 2 + RL) chk("r_rsp_early", 32'(rsp_valid), 32'h0);
      else begin
        chk("r_rsp", 32'(rsp_valid), 32'h2);
        chk("r_rdata", rsp_rdata, 32'hDEADBEEF);
      end
    end

    // Contention between requesters 0 and 1, six writes each
    cnt[0] = 0; cnt[1] = 0; cc = 0;
    cyc(); req_valid = 3'b011; req_wr = 3'b011;
    req_addr[31:0] = 32'h100; req_addr[63:32] = 32'h200;
    req_wdata[31:0] = $urandom; req_wdata[63:32] = $urandom;
    while (order.size() < 12 && cc < 200) begin
      smp();
      lastAcc = req_ready[1:0];
      for (int i = 0; i < 2; i++) if (lastAcc[i]) begin order.push_back(i); accCyc.push_back(cc); end
      chk("c_rsp_onehot", 32'($onehot0(rsp_valid)), 32'h1);
      cyc(); cc++;
      for (int i = 0; i < 2; i++) if (lastAcc[i]) begin
        cnt[i]++;
        if (cnt[i] == 6) req_valid[i] = 1'b0;
        else begin
          req_addr[i*32 +: 32] = req_addr[i*32 +: 32] + 32'h4;
          req_wdata[i*32 +: 32] = $urandom;
        end
      end
    end
    chk("c_count", 32'(order.size()), 32'd12);
    for (int k = 0; k < order.size(); k++) begin
`ifdef PICOBUS_ARB_PRIO_EN
      chk("c_order", 32'(order[k]), (k < 6) ? 32'd0 : 32'd1);
`else
      chk("c_order", 32'(order[k]), 32'(k % 2));
`endif
      if (k > 0) chk("c_spacing", 32'(accCyc[k] - accCyc[k-1]), 32'd3);
    end
    repeat (4) cyc();

    // Reset during WAIT of a read
    req_valid = 3'b100; req_wr = '0; req_addr[95:64] = 32'h30;
    smp(); chk("rr_ready", 32'(req_ready), 32'h4);
    cyc(); req_valid = '0; smp();
    cyc(); smp();
    #1 PicoRst_n = 1'b0;
    #1;
    chk("rr_rd_now", 32'(PicoRd), 32'h0); chk("rr_busy_now", 32'(busy), 32'h0);
    chk("rr_gid_now", 32'(grant_id), 32'h0); chk("rr_addr_now", PicoAddr, 32'h0);
    cyc(); cyc(); PicoRst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      smp(); chk("rr_no_rsp", 32'(rsp_valid), 32'h0);
      cyc();
    end
    req_valid = 3'b011; req_wr = 3'b011;
    smp(); chk("rr_first_grant", 32'(req_ready), 32'h1);
    cyc(); req_valid = '0;
    repeat (4) cyc();

    // Withdrawn request from requester 1 during ISSUE
    req_valid = 3'b001; req_wr = 3'b001;
    smp(); chk("wd_ready0", 32'(req_ready), 32'h1);
    cyc(); req_valid = 3'b010;
    smp(); chk("wd_no_ready", 32'(req_ready), 32'h0);
    cyc(); req_valid = '0; smp();
    for (int n = 0; n < 4; n++) begin
      cyc(); smp();
      chk("wd_busy", 32'(busy), 32'h0);
      chk("wd_gid", 32'(grant_id), 32'h0);
    end

    // Randomized traffic
    acc = '0;
    for (int n = 0; n < 3000; n++) begin
      cyc();
      PicoDataOut = $urandom;
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && acc[i]) req_valid[i] = 1'b0;
        else if (req_valid[i] && $urandom_range(15) == 0) req_valid[i] = 1'b0;
        else if (!req_valid[i] && $urandom_range(2) == 0) begin
          req_valid[i] = 1'b1;
          req_wr[i] = 1'($urandom_range(1));
          req_addr[i*32 +: 32] = $urandom;
          req_wdata[i*32 +: 32] = $urandom;
        end
      end
      smp();
      acc = req_ready;
    end
    cyc(); req_valid = '0;
    repeat (12) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
